// File: rtl/arb_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
package arb_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned STRB_W   = 4;

  typedef enum logic {
    IDLE,
    WAIT_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants taken while fetch waits; raises force_fetch at the limit.
module arb_starve_cnt #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic fetch_cand,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic force_fetch
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // Only a data grant that actually overtakes a live fetch request counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!if_req || if_gnt) begin
      cnt_q <= '0;
    end else if (d_gnt && fetch_cand && (cnt_q != CW'(LIMIT))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign force_fetch = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store with a single outstanding read.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  logic       drop_q, drop_d;
  logic       fetch_cand;
  logic       sel_if;
  logic       accept;
  logic       force_fetch;

  assign fetch_cand = if_req & ~flush;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .fetch_cand (fetch_cand),
    .if_gnt     (if_gnt),
    .d_gnt      (d_gnt),
    .force_fetch(force_fetch)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_fetch = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
    end
  end

  // Outputs are held at zero while reset is asserted, independent of request inputs.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    drop_d    = drop_q;
    sel_if    = 1'b0;
    accept    = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          sel_if  = fetch_cand & (~d_req | force_fetch);
          mem_req = fetch_cand | d_req;
          accept  = mem_req & mem_ready;
          if (sel_if) begin
            mem_addr = if_addr;
          end else if (d_req) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_wstrb;
          end
          if_gnt = sel_if & accept;
          d_gnt  = ~sel_if & accept;
          // Stores retire on acceptance; only reads wait for a response.
          if (accept && (sel_if || !d_we)) begin
            state_d = WAIT_RESP;
            owner_d = sel_if ? OWN_IF : OWN_D;
            drop_d  = 1'b0;
          end
        end
        WAIT_RESP: begin
          if ((owner_q == OWN_IF) && flush) begin
            drop_d = 1'b1;
          end
          if (mem_rvalid) begin
            if (owner_q == OWN_D) begin
              d_rvalid = 1'b1;
              d_rdata  = mem_rdata;
            end else if (!drop_d) begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
            drop_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single unified memory port between the instruction-fetch stage and the load/store (MEM) stage. It accepts one request at a time and enforces a single outstanding read. Read data returns only to the requester that issued the read, and a pipeline flush can cancel an in-flight fetch response. The block sits between the fetch/MEM stages and the memory bus; a denied grant is the stage's stall condition.

## Interface
- XLEN, 32: address/data width
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch is waiting (guard feature only)

- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request
- if_addr  in  XLEN  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  XLEN  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_wstrb  in  4  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  XLEN  load data
- flush  in  1  branch/jump redirect; cancels fetch
- mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/1/XLEN/XLEN/4  memory request
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read response valid; reads only, in order
- mem_rdata  in  XLEN  read response data

## Operation
- FSM states: IDLE, WAIT_RESP. Registers: owner (IF/D), drop flag.
- **IDLE arbitration** (combinational):
  - Fetch candidate is if_req & ~flush.
  - Data wins over fetch by default.
  - mem_* outputs carry the selected requester's fields.
  - Accept = mem_req & mem_ready. The winner's gnt equals accept.
  - The losing requester sees gnt = 0.
- **Accepted store**: completes on acceptance. No response is expected. State stays IDLE.
- **Accepted read** (any fetch, or a load):
  - Go to WAIT_RESP.
  - owner <= requester; drop <= 0.
- **WAIT_RESP**:
  - mem_req = 0 and both gnt = 0.
  - flush while owner = IF sets drop.
  - flush has no effect when owner = D.
  - On mem_rvalid, the response goes to the owner's rvalid/rdata, except when owner = IF and drop is set (or flush is asserted that same cycle): the response is discarded.
  - Then return to IDLE.
- mem_rvalid in IDLE (stale, e.g. after reset) is ignored. It never reaches either port.
- rdata outputs pass mem_rdata through. They are only meaningful while the matching rvalid is high.

## Timing
- Reset values:
  - state = IDLE, owner = IF, drop = 0, starve count = 0.
  - All gnt, rvalid and mem_req outputs are 0.
  - All data/address outputs are 0.
- Grant is the same cycle as mem_ready (zero-cycle arbitration).
- Read response reaches the requester in the mem_rvalid cycle (zero added latency).
- The first new request after a response is issued the cycle after mem_rvalid. Maximum read throughput is therefore one per two cycles with 1-cycle memory.
- Stores are back-to-back capable: one per cycle while mem_ready is high.
- Reset mid-read: the outstanding response is lost. The late mem_rvalid falls under the IDLE-ignore rule.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter tracks consecutive data grants taken while if_req is high and not flushed.
  - When the counter reaches STARVE_LIMIT, the next IDLE arbitration grants fetch even if d_req is high.
  - The counter clears on any fetch grant, and whenever if_req is low.
  - The counter saturates at STARVE_LIMIT.
- ARB_STARVE_GUARD_EN undefined: strict data priority. No counter logic is present, and STARVE_LIMIT is unused.

## Structure
- Shared package arb_pkg: state enum (IDLE, WAIT_RESP), owner enum (OWN_IF, OWN_D), default XLEN.
- Sub-module arb_starve_cnt holds the saturating counter and the force-fetch output. It is instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- **Both read at once**: if_req and d_req (load, 0x100) high in IDLE with mem_ready=1 → d_gnt=1, if_gnt=0, mem_addr=0x100. mem_rvalid two cycles later with 0xDEADBEEF → d_rvalid=1, d_rdata=0xDEADBEEF, if_rvalid=0.
- **Store then fetch**: d_we=1, addr 0x40, wstrb 0xF, if_req high, mem_ready=1 for 2 cycles → store granted cycle 0, fetch granted cycle 1. No response is routed for the store.
- **Flush cancels fetch**: fetch 0x200 granted, flush pulsed in WAIT_RESP, mem_rvalid 3 cycles later → if_rvalid stays 0, FSM returns to IDLE.
- **Memory backpressure**: mem_ready=0 for 5 cycles with if_req high → if_gnt=0, mem_req=1 and mem_addr stable throughout. Grant occurs in the cycle mem_ready rises.
- **Starvation guard** (ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, stores every cycle, if_req high) → 4 data grants, then 1 fetch grant. Without the macro, zero fetch grants occur.
- **Reset mid-read**: rst_n low during WAIT_RESP → all outputs are 0 immediately. A mem_rvalid after reset produces no rvalid on either port.
